// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle, sign fixed at the end.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e           stateQ, stateD;
    logic [CW-1:0]    cntQ;
    logic             isDivQ, negResQ, negRemQ;
    logic [WIDTH-1:0] accHiQ, accLoQ, bQ, aOrigQ;
    logic [WIDTH-1:0] hiQ, loQ;
    logic             doneQ, dbzQ;

    logic             accept, lastIter;
    logic             signedOp, aNeg, bNeg;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH:0]   mulSum, divShift;
    logic             divGe;
    logic [WIDTH-1:0] divRem;
    logic [2*WIDTH-1:0] product, productFix;
    logic [WIDTH-1:0] quotFix, remFix;
    logic             divZero;

    assign accept   = (stateQ == IDLE) && start_i;
    assign lastIter = (cntQ == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (start_i)  stateD = RUN;
            RUN:     if (lastIter) stateD = FIX;
            FIX:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (stateQ != IDLE);
    end

    // Signed ops run on magnitudes; the most-negative value maps onto itself as an unsigned magnitude.
    assign signedOp = op_i[0];
    assign aNeg     = signedOp & a_i[WIDTH-1];
    assign bNeg     = signedOp & b_i[WIDTH-1];
    assign aMag     = aNeg ? -a_i : a_i;
    assign bMag     = bNeg ? -b_i : b_i;

    assign mulSum   = {1'b0, accHiQ} + (accLoQ[0] ? {1'b0, bQ} : '0);
    assign divShift = {accHiQ, accLoQ[WIDTH-1]};
    assign divGe    = (divShift >= {1'b0, bQ});
    assign divRem   = divShift[WIDTH-1:0] - bQ;

    assign product    = {accHiQ, accLoQ};
    assign productFix = negResQ ? -product : product;
    assign quotFix    = negResQ ? -accLoQ : accLoQ;
    assign remFix     = negRemQ ? -accHiQ : accHiQ;
    assign divZero    = isDivQ && (bQ == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ    <= '0;
            isDivQ  <= 1'b0;
            negResQ <= 1'b0;
            negRemQ <= 1'b0;
            accHiQ  <= '0;
            accLoQ  <= '0;
            bQ      <= '0;
            aOrigQ  <= '0;
            hiQ     <= '0;
            loQ     <= '0;
            doneQ   <= 1'b0;
            dbzQ    <= 1'b0;
        end else begin
            doneQ <= (stateQ == FIX);
            if (accept) begin
                cntQ    <= '0;
                isDivQ  <= op_i[1];
                negResQ <= aNeg ^ bNeg;
                negRemQ <= aNeg;
                accHiQ  <= '0;
                accLoQ  <= aMag;
                bQ      <= bMag;
                aOrigQ  <= a_i;
                dbzQ    <= 1'b0;
            end else if (stateQ == RUN) begin
                cntQ <= cntQ + 1'b1;
                if (isDivQ) begin
                    accHiQ <= divGe ? divRem : divShift[WIDTH-1:0];
                    accLoQ <= {accLoQ[WIDTH-2:0], divGe};
                end else begin
                    accHiQ <= mulSum[WIDTH:1];
                    accLoQ <= {mulSum[0], accLoQ[WIDTH-1:1]};
                end
            end else if (stateQ == FIX) begin
                dbzQ <= divZero;
                if (divZero) begin
                    hiQ <= aOrigQ;
                    loQ <= '1;
                end else if (isDivQ) begin
                    hiQ <= remFix;
                    loQ <= quotFix;
                end else begin
                    hiQ <= productFix[2*WIDTH-1:WIDTH];
                    loQ <= productFix[WIDTH-1:0];
                end
            end
        end
    end

    assign done_o        = doneQ;
    assign div_by_zero_o = dbzQ;
    assign hi_o          = hiQ;
    assign lo_o          = loQ;

endmodule
